unpack_arb: RTL and testbench

Two-requester round-robin arbiter and init sequencer for a 20-entry × 11-bit unpacked-array register file with asynchronous read and clocked write. Each cycle it grants at most one requester access to the storage's single address/write port, returns read data one cycle later, and blocks out-of-range indices. The array itself sits outside the block, and `unpack_arb` is its only master. An optional init phase clears every entry after reset.

---
 rtl/unpack_arb_if.sv | 25 ++
 rtl/unpack_arb.sv | 112 +++++++++++
 tb/tb_unpack_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unpack_arb_if.sv
// unpack_arb_if: one requester's request/response channel into unpack_arb.
// The master drives requests; the slave (arbiter) returns ready and read responses.
interface unpack_arb_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned WIDTH = 11
);
  logic             valid;
  logic             ready;
  logic             wr;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output valid, wr, idx, data,
    input  ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  valid, wr, idx, data,
    output ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/unpack_arb.sv
// unpack_arb: two-requester round-robin arbiter for an external DEPTH x WIDTH register file.
// Define UNPACK_ARB_INIT_EN to clear every entry after reset before accepting requests.
module unpack_arb #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned WIDTH = 11,
  parameter int unsigned AW    = 5
) (
  input  logic             ck,
  input  logic             rst,
  unpack_arb_if.slave      req0,
  unpack_arb_if.slave      req1,
  output logic [AW-1:0]    mem_idx,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] mem_rslt,
  output logic             init_busy
);

  localparam int unsigned AWX = AW + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef UNPACK_ARB_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_t RST_STATE = ST_RUN;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t           r_state;
  logic [AW-1:0]    r_ic;
  logic             r_pri;
  logic             r_init_busy;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic             r_rsp0_err, r_rsp1_err;
  logic [WIDTH-1:0] r_rsp0_data, r_rsp1_data;

  logic             w_run, w_gnt0, w_gnt1, w_gnt, w_wr, w_inr;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] w_data;

  // Grant selection: a lone requester wins, a tie goes to r_pri.
  always_comb begin
    w_run  = (r_state == ST_RUN) && !rst;
    w_gnt0 = w_run && req0.valid && (!req1.valid || !r_pri);
    w_gnt1 = w_run && req1.valid && (!req0.valid || r_pri);
    w_gnt  = w_gnt0 || w_gnt1;
    w_idx  = w_gnt1 ? req1.idx  : req0.idx;
    w_wr   = w_gnt1 ? req1.wr   : req0.wr;
    w_data = w_gnt1 ? req1.data : req0.data;
    w_inr  = {1'b0, w_idx} < AWX'(DEPTH);
  end

  // Storage port: init sweep, granted access, or idle at index 0.
  always_comb begin
    mem_wr   = 1'b0;
    mem_idx  = '0;
    mem_data = '0;
    if ((r_state == ST_INIT) && !rst) begin
      mem_wr  = 1'b1;
      mem_idx = r_ic;
    end else if (w_gnt) begin
      mem_wr   = w_wr && w_inr;
      mem_idx  = w_inr ? w_idx : '0;
      mem_data = w_data;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state      <= RST_STATE;
      r_ic         <= '0;
      r_init_busy  <= RST_BUSY;
      r_pri        <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_rsp0_valid <= w_gnt0 && (!w_wr || !w_inr);
      r_rsp1_valid <= w_gnt1 && (!w_wr || !w_inr);
      r_rsp0_err   <= w_gnt0 && !w_inr;
      r_rsp1_err   <= w_gnt1 && !w_inr;
      r_rsp0_data  <= (w_gnt0 && !w_wr && w_inr) ? mem_rslt : '0;
      r_rsp1_data  <= (w_gnt1 && !w_wr && w_inr) ? mem_rslt : '0;
      // Priority passes to whichever requester was not granted.
      if (w_gnt) r_pri <= w_gnt0;
      if (r_state == ST_INIT) begin
        r_ic <= r_ic + 1'b1;
        if (r_ic == AW'(DEPTH - 1)) begin
          r_state     <= ST_RUN;
          r_init_busy <= 1'b0;
          r_ic        <= '0;
        end
      end
    end
  end

  assign init_busy      = r_init_busy;
  assign req0.ready     = w_gnt0;
  assign req1.ready     = w_gnt1;
  assign req0.rsp_valid = r_rsp0_valid;
  assign req1.rsp_valid = r_rsp1_valid;
  assign req0.rsp_err   = r_rsp0_err;
  assign req1.rsp_err   = r_rsp1_err;
  assign req0.rsp_data  = r_rsp0_data;
  assign req1.rsp_data  = r_rsp1_data;

endmodule

// File: tb/tb_unpack_arb.sv
// tb_unpack_arb: randomized and directed checks of unpack_arb against a cycle-level reference
// model; the register file lives here. Honors UNPACK_ARB_INIT_EN like the design.
module tb_unpack_arb;
  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 11;
  localparam int unsigned AW    = 5;
`ifdef UNPACK_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  unpack_arb_if #(.AW(AW), .WIDTH(WIDTH)) r0 ();
  unpack_arb_if #(.AW(AW), .WIDTH(WIDTH)) r1 ();

  logic [AW-1:0]    mem_idx;
  logic             mem_wr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_rslt;
  logic             init_busy;

  unpack_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .ck(ck), .rst(rst), .req0(r0), .req1(r1),
    .mem_idx(mem_idx), .mem_wr(mem_wr), .mem_data(mem_data),
    .mem_rslt(mem_rslt), .init_busy(init_busy)
  );

  // Register file: asynchronous read, clocked write.
  logic [WIDTH-1:0] store [32];
  assign mem_rslt = store[mem_idx];
  always @(posedge ck) if (mem_wr) store[mem_idx] <= mem_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state (post-reset values).
  int               m_pri       = 0;
  int               m_init_left = INIT_EN ? DEPTH : 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               ref_known [DEPTH];
  bit               e_busy = INIT_EN;
  bit               e_v [2] = '{0, 0};
  bit               e_e [2] = '{0, 0};
  bit               e_dchk [2] = '{0, 0};
  logic [WIDTH-1:0] e_d [2] = '{0, 0};

  // Stimulus slots for the next cycle.
  bit s_rst;
  bit s_v [2];
  bit s_w [2];
  int s_i [2];
  int s_d [2];
  int last_g;

  task automatic put(input int n, input bit w, input int idx, input int d);
    s_v[n] = 1'b1; s_w[n] = w; s_i[n] = idx; s_d[n] = d;
  endtask

  // One clock cycle: check registered outputs, apply inputs, check combinational outputs, advance model.
  task automatic cyc();
    int g, ix;
    bit inr, ew;
    int ei, ed;
    chk("init_busy", 32'(init_busy), 32'(e_busy));
    chk("rsp0_valid", 32'(r0.rsp_valid), 32'(e_v[0]));
    chk("rsp1_valid", 32'(r1.rsp_valid), 32'(e_v[1]));
    if (e_v[0]) chk("rsp0_err", 32'(r0.rsp_err), 32'(e_e[0]));
    if (e_v[1]) chk("rsp1_err", 32'(r1.rsp_err), 32'(e_e[1]));
    if (e_v[0] && e_dchk[0]) chk("rsp0_data", 32'(r0.rsp_data), 32'(e_d[0]));
    if (e_v[1] && e_dchk[1]) chk("rsp1_data", 32'(r1.rsp_data), 32'(e_d[1]));

    rst = s_rst;
    r0.valid = s_v[0]; r0.wr = s_w[0]; r0.idx = AW'(s_i[0]); r0.data = WIDTH'(s_d[0]);
    r1.valid = s_v[1]; r1.wr = s_w[1]; r1.idx = AW'(s_i[1]); r1.data = WIDTH'(s_d[1]);
    #1;

    g = -1;
    if (!s_rst && m_init_left == 0) begin
      if (s_v[0] && s_v[1]) g = m_pri;
      else if (s_v[0]) g = 0;
      else if (s_v[1]) g = 1;
    end
    last_g = g;
    chk("ready0", 32'(r0.ready), 32'(g == 0));
    chk("ready1", 32'(r1.ready), 32'(g == 1));

    ew = 1'b0; ei = 0; ed = 0; inr = 1'b0; ix = 0;
    if (!s_rst && m_init_left > 0) begin
      ew = 1'b1; ei = DEPTH - m_init_left;
    end else if (g >= 0) begin
      ix = s_i[g]; inr = ix < DEPTH;
      ew = s_w[g] && inr; ei = inr ? ix : 0; ed = s_d[g];
    end
    chk("mem_wr", 32'(mem_wr), 32'(ew));
    chk("mem_idx", 32'(mem_idx), 32'(ei));
    chk("mem_data", 32'(mem_data), 32'(ed));

    e_v = '{0, 0}; e_e = '{0, 0}; e_dchk = '{0, 0}; e_d = '{0, 0};
    if (s_rst) begin
      m_pri = 0;
      e_busy = INIT_EN;
      m_init_left = INIT_EN ? DEPTH : 0;
      if (INIT_EN) for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b1; end
    end else if (m_init_left > 0) begin
      m_init_left--;
      e_busy = (m_init_left > 0);
    end else if (g >= 0) begin
      e_v[g] = !s_w[g] || !inr;
      e_e[g] = !inr;
      e_dchk[g] = !inr || ref_known[ix];
      e_d[g] = (!s_w[g] && inr) ? ref_mem[ix] : '0;
      if (s_w[g] && inr) begin ref_mem[ix] = WIDTH'(s_d[g]); ref_known[ix] = 1'b1; end
      m_pri = 1 - g;
    end
    s_rst = 1'b0; s_v = '{0, 0}; s_w = '{0, 0};
    @(posedge ck);
    @(negedge ck);
  endtask

  // Issue one access on requester n and retry until it is granted (bounded).
  task automatic access(input int n, input bit w, input int idx, input int d);
    int tries = 0;
    do begin
      put(n, w, idx, d);
      cyc();
      tries++;
    end while (last_g != n && tries < 100);
    chk("grant_timeout", 32'(last_g), 32'(n));
  endtask

  task automatic do_reset();
    s_rst = 1'b1; cyc();
    s_rst = 1'b1; cyc();
  endtask

  initial begin
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = INIT_EN; end
    rst = 1'b1;
    r0.valid = 1'b0; r0.wr = 1'b0; r0.idx = '0; r0.data = '0;
    r1.valid = 1'b0; r1.wr = 1'b0; r1.idx = '0; r1.data = '0;
    s_rst = 1'b0; s_v = '{0, 0}; s_w = '{0, 0}; s_i = '{0, 0}; s_d = '{0, 0};
    @(posedge ck);
    @(negedge ck);
    do_reset();

    // Init sweep: count busy cycles while req0 keeps asking for reads 0..19.
    busy_cycles = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (init_busy) busy_cycles++;
      access(0, 1'b0, k, 0);
      busy_cycles += (k == 0) ? (INIT_EN ? DEPTH - 1 : 0) : 0;
    end
    chk("init_busy_len", 32'(busy_cycles), INIT_EN ? DEPTH : 0);

    // Populate every entry so later reads have known contents.
    for (int k = 0; k < DEPTH; k++) access(0, 1'b1, k, int'($urandom_range(0, 2047)));

    // Write on req0 then read back on req1 the very next cycle.
    put(0, 1'b1, 7, 'h5A3); cyc();
    chk("wr_grant", 32'(last_g), 0);
    put(1, 1'b0, 7, 0); cyc();
    chk("rb_valid", 32'(r1.rsp_valid), 1);
    chk("rb_data", 32'(r1.rsp_data), 'h5A3);
    cyc();

    // Round robin from reset: grants alternate starting with req0.
    do_reset();
    for (int k = 0; k < 40 && m_init_left > 0; k++) cyc();
    for (int k = 0; k < 8; k++) begin
      put(0, 1'b0, 1, 0); put(1, 1'b0, 2, 0); cyc();
      chk("rr_grant", 32'(last_g), 32'(k % 2));
    end
    cyc();

    // Out-of-range write and read; neither touches storage.
    put(1, 1'b1, 25, 'h7FF); cyc();
    chk("oor_wr_mem_wr", 32'(mem_wr), 0);
    chk("oor_wr_err", 32'(r1.rsp_err), 1);
    put(1, 1'b0, 20, 0); cyc();
    chk("oor_rd_err", 32'(r1.rsp_err), 1);
    chk("oor_rd_data", 32'(r1.rsp_data), 0);
    access(0, 1'b0, 0, 0);
    cyc();

    // Highest valid index.
    access(0, 1'b1, 19, 'h001);
    access(0, 1'b0, 19, 0);
    chk("b19_data", 32'(r0.rsp_data), 'h001);
    chk("b19_err", 32'(r0.rsp_err), 0);
    cyc();

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      for (int n = 0; n < 2; n++)
        if ($urandom_range(0, 3) != 0) put(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                                           int'($urandom_range(0, 2047)));
      s_rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    cyc();
    for (int k = 0; k < 40 && m_init_left > 0; k++) cyc();

    // Reset right after a read grant: the pending response must not survive the reset edge.
    access(0, 1'b1, 7, 'h2C4);
    access(0, 1'b0, 7, 0);
    s_rst = 1'b1; cyc();
    chk("rst_drop0", 32'(r0.rsp_valid), 0);
    chk("rst_drop1", 32'(r1.rsp_valid), 0);
    access(0, 1'b0, 7, 0);
`ifdef UNPACK_ARB_INIT_EN
    chk("post_init_idx7", 32'(r0.rsp_data), 0);
`else
    chk("post_rst_idx7", 32'(r0.rsp_data), 'h2C4);
`endif
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
